// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: width helper, FSM encoding
// and the widths of the default configuration.
package fifo_arb_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned MAXBURST_DEF = 4;

  localparam int unsigned GID_W = clog2(NREQ_DEF);
  localparam int unsigned CNT_W = clog2(MAXBURST_DEF + 1);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// The slave modport is the arbiter itself; the master modport is its environment.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned NREQ     = 4
);

  localparam int unsigned GW = clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_last;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     wfull;
  logic                     w_req_val;
  logic [DATASIZE-1:0]      wdata;
  logic [GW-1:0]            grant_id;
  logic                     busy;

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, w_req_val, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, w_req_val, wdata, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or above the pointer, wrapping
// modulo NREQ (NREQ need not be a power of two).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned GW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_ptr,
  output logic [GW-1:0]   o_idx,
  output logic            o_any
);

  int unsigned w_cand;

  always_comb begin
    o_idx  = i_ptr;
    o_any  = 1'b0;
    w_cand = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = 32'(i_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!o_any && i_req[GW'(w_cand)]) begin
        o_any = 1'b1;
        o_idx = GW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async-FIFO write port among NREQ requesters: round-robin grant held
// for a packet, capped at MAXBURST beats, with wfull backpressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int unsigned     GW       = clog2(NREQ);
  localparam int unsigned     CW       = clog2(MAXBURST + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAXBURST - 1);
  localparam logic [GW-1:0]   GID_MAX  = GW'(NREQ - 1);

  logic                r_state;
  logic                w_state_nxt;
  logic [GW-1:0]       r_gid;
  logic [GW-1:0]       w_gid_nxt;
  logic [GW-1:0]       r_ptr;
  logic [GW-1:0]       w_ptr_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [GW-1:0]       w_win;
  logic                w_any;
  logic                w_accept;
  logic                w_release;
  logic [NREQ-1:0]     w_ready;
  logic                w_wval;
  logic [DATASIZE-1:0] w_wdata;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_accept  = (r_state == BUSY) & bus.req_valid[r_gid] & ~bus.wfull;
  // A forced release at the burst cap looks the same as end-of-packet here.
  assign w_release = w_accept & (bus.req_last[r_gid] | (r_cnt == CNT_LAST));

  // State register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Grant, pointer and beat counter registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_gid <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_gid <= w_gid_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_gid_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_gid == GID_MAX) ? '0 : r_gid + 1'b1;
          w_cnt_nxt   = '0;
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // Output steering; everything is zero outside a grant
  always_comb begin
    w_ready = '0;
    w_wval  = 1'b0;
    w_wdata = '0;
    if (r_state == BUSY) begin
      w_ready[r_gid] = ~bus.wfull;
      w_wval         = w_accept;
      w_wdata        = bus.req_data[32'(r_gid) * DATASIZE +: DATASIZE];
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.w_req_val = w_wval;
  assign bus.wdata     = w_wdata;
  assign bus.grant_id  = r_gid;
  assign bus.busy      = r_state;

endmodule
